// File: rtl/mem_dcache_stage.sv
// rtl/mem_dcache_stage.sv - MEM-stage direct-mapped write-through data cache with pipeline hold
module mem_dcache_stage #(
  parameter int INDEX_BITS     = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_alu_out,
  input  logic [31:0] write_data,
  input  logic        memread,
  input  logic        memwrite,
  output logic [7:0]  data_out [0:3],
  output logic        hold,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int DEPTH    = LINES * WORDS_PER_LINE;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_STORE, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           beat_q, beat_d;
  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [31:0]          line_q [DEPTH];

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic [31:0]           cached_word;
  logic                  refill_beat;
  logic                  refill_last;
  logic                  unused_addr_bits;

  logic        hold_c, req_c, we_c;
  logic [31:0] addr_c, wdata_c, rd_word;

  assign offset           = MEM_alu_out[3:2];
  assign index            = MEM_alu_out[INDEX_BITS+3:4];
  assign tag              = MEM_alu_out[31:INDEX_BITS+4];
  assign unused_addr_bits = ^MEM_alu_out[1:0];
  assign hit              = valid_q[index] && (tag_q[index] == tag);
  assign cached_word      = line_q[{index, offset}];
  assign refill_beat      = (state_q == S_REFILL) && mem_ready;
  assign refill_last      = refill_beat && (beat_q == 2'd3);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    hold_c  = 1'b0;
    req_c   = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    rd_word = '0;
    case (state_q)
      S_IDLE: begin
        if (memwrite) begin
          hold_c  = 1'b1;
          state_d = S_STORE;
        end else if (memread) begin
          if (hit) begin
            rd_word = cached_word;
          end else begin
            hold_c  = 1'b1;
            state_d = S_REFILL;
            beat_d  = '0;
          end
        end
      end
      S_REFILL: begin
        hold_c = 1'b1;
        req_c  = 1'b1;
        addr_c = {tag, index, beat_q, 2'b00};
        if (mem_ready) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = S_IDLE;
        end
      end
      S_STORE: begin
        hold_c  = 1'b1;
        req_c   = 1'b1;
        we_c    = 1'b1;
        addr_c  = {MEM_alu_out[31:2], 2'b00};
        wdata_c = write_data;
        if (mem_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset forces the outputs quiet even though the input operands may still request an access.
  assign hold      = hold_c & ~rst;
  assign mem_req   = req_c & ~rst;
  assign mem_we    = we_c & ~rst;
  assign mem_addr  = rst ? '0 : addr_c;
  assign mem_wdata = rst ? '0 : wdata_c;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      data_out[i] = rst ? 8'h00 : rd_word[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if ((state_q == S_IDLE) && (state_d == S_REFILL)) begin
        valid_q[index] <= 1'b0;
      end else if (refill_last) begin
        valid_q[index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (refill_beat) begin
      line_q[{index, beat_q}] <= mem_rdata;
    end else if ((state_q == S_STORE) && mem_ready && hit) begin
      line_q[{index, offset}] <= write_data;
    end
    if (refill_last) tag_q[index] <= tag;
  end

endmodule
